// File: rtl/bitstream_fetch_ctrl_pkg.sv
// rtl/bitstream_fetch_ctrl_pkg.sv - shared types and constants for the bitstream fetch controller
package bitstream_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_WAIT_BYTE
    } fetch_state_t;

    localparam logic signed [3:0] BN_RESET          = -4'sd8;
    localparam int                MAX_BYPASS_BINS   = 3;
    localparam logic              CONS_MODE_REGULAR = 1'b0;
    localparam logic              CONS_MODE_BYPASS  = 1'b1;

endpackage

// File: rtl/bitstream_prefetch_buf.sv
// rtl/bitstream_prefetch_buf.sv - single-entry valid/ready byte buffer for the fetch prefetch path
module bitstream_prefetch_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready
);

    logic       full_q;
    logic [7:0] data_q;

    assign s_tready = !full_q;
    assign m_tvalid = full_q;
    assign m_tdata  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= 8'h00;
        end else if (clear) begin
            full_q <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            full_q <= 1'b1;
            data_q <= s_tdata;
        end else if (m_tvalid && m_tready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/bitstream_fetch_ctrl.sv
// rtl/bitstream_fetch_ctrl.sv - CABAC bitstream byte fetch controller; optional prefetch via BITSTREAM_FETCH_PREFETCH_EN
module bitstream_fetch_ctrl
    import bitstream_fetch_ctrl_pkg::*;
#(
    parameter int INIT_BYTES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              cons_valid,
    output logic              cons_ready,
    input  logic              cons_mode,
    input  logic [2:0]        cons_bits,
    output logic [7:0]        bitstream,
    output logic signed [3:0] bits_needed,
    output logic signed [3:0] bits_needed_sel,
    output logic              flag,
    output logic              re_add,
    output logic [15:0]       init_word,
    output logic              init_valid,
    output logic              err
);

    localparam logic [1:0] INIT_LAST = 2'(INIT_BYTES - 1);

    fetch_state_t      state_q, state_d;
    logic signed [3:0] bn_q;
    logic [1:0]        init_cnt_q;
    logic              held_mode_q;
    logic signed [4:0] held_s_q;

    logic signed [4:0] sum, cur_s;
    logic signed [3:0] bn_after;
    logic              bypass_bad, need_byte, cons_fire, byte_fire;
    logic              take_byte, byte_avail, run_byte_ready, cur_mode;
    logic              pf_valid;
    logic [7:0]        pf_data, byte_sel;

    assign sum        = $signed({bn_q[3], bn_q}) + $signed({2'b00, cons_bits});
    assign bypass_bad = (cons_mode == CONS_MODE_BYPASS) &&
                        ((cons_bits == 3'd0) || (cons_bits > 3'(MAX_BYPASS_BINS)));
    assign need_byte  = !bypass_bad && !sum[4];
    assign cons_fire  = cons_valid && cons_ready;
    assign byte_fire  = byte_valid && byte_ready;
    assign byte_avail = pf_valid || byte_valid;
    assign byte_sel   = pf_valid ? pf_data : byte_in;
    // A held request in WAIT_BYTE completes with the mode and sum captured at acceptance
    assign cur_mode   = (state_q == ST_WAIT_BYTE) ? held_mode_q : cons_mode;
    assign cur_s      = (state_q == ST_WAIT_BYTE) ? held_s_q : sum;
    assign bn_after   = 4'(cur_s - 5'sd8);

`ifdef BITSTREAM_FETCH_PREFETCH_EN
    logic pf_ready, pf_load;

    assign pf_load        = (state_q == ST_RUN) && !start && byte_valid && pf_ready && !take_byte;
    assign run_byte_ready = pf_ready;

    bitstream_prefetch_buf u_prefetch (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .s_tdata  (byte_in),
        .s_tvalid (pf_load),
        .s_tready (pf_ready),
        .m_tdata  (pf_data),
        .m_tvalid (pf_valid),
        .m_tready (take_byte)
    );
`else
    assign pf_valid       = 1'b0;
    assign pf_data        = 8'h00;
    assign run_byte_ready = cons_valid && need_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Readies drop while start is high so a restart never swallows a transfer
    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        cons_ready = 1'b0;
        take_byte  = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_INIT: begin
                byte_ready = !start;
                if (byte_valid && !start && (init_cnt_q == INIT_LAST)) state_d = ST_RUN;
            end
            ST_RUN: begin
                cons_ready = !start;
                byte_ready = !start && run_byte_ready;
                if (cons_fire && need_byte) begin
                    if (byte_avail) take_byte = 1'b1;
                    else            state_d   = ST_WAIT_BYTE;
                end
            end
            ST_WAIT_BYTE: begin
                byte_ready = !start;
                if (byte_valid && !start) begin
                    take_byte = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) state_d = ST_INIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bn_q            <= BN_RESET;
            init_cnt_q      <= 2'd0;
            held_mode_q     <= CONS_MODE_REGULAR;
            held_s_q        <= 5'sd0;
            bitstream       <= 8'h00;
            bits_needed     <= 4'sd0;
            bits_needed_sel <= 4'sd0;
            flag            <= 1'b0;
            re_add          <= 1'b0;
            init_word       <= 16'h0000;
            init_valid      <= 1'b0;
            err             <= 1'b0;
        end else begin
            flag       <= 1'b0;
            re_add     <= 1'b0;
            init_valid <= 1'b0;
            err        <= 1'b0;
            if (start) begin
                init_cnt_q <= 2'd0;
                init_word  <= 16'h0000;
            end else begin
                if (state_q == ST_INIT && byte_fire) begin
                    init_word  <= {init_word[7:0], byte_in};
                    init_cnt_q <= init_cnt_q + 2'd1;
                    if (init_cnt_q == INIT_LAST) begin
                        init_valid <= 1'b1;
                        bn_q       <= BN_RESET;
                    end
                end
                if (state_q == ST_RUN && cons_fire) begin
                    if (bypass_bad) begin
                        err <= 1'b1;
                    end else begin
                        if (cons_mode == CONS_MODE_BYPASS) bits_needed_sel <= bn_q;
                        if (!need_byte) begin
                            bn_q <= sum[3:0];
                        end else if (!take_byte) begin
                            held_mode_q <= cons_mode;
                            held_s_q    <= sum;
                        end
                    end
                end
                if (take_byte) begin
                    bitstream <= byte_sel;
                    bn_q      <= bn_after;
                    if (cur_mode == CONS_MODE_REGULAR) begin
                        bits_needed <= cur_s[3:0];
                        re_add      <= 1'b1;
                    end else begin
                        flag <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// tb/tb_bitstream_fetch_ctrl.sv - scoreboard bench for bitstream_fetch_ctrl (default build)
module tb_bitstream_fetch_ctrl;

    logic              clk = 1'b0;
    logic              rst_n, start, byte_valid, cons_valid, cons_mode;
    logic [7:0]        byte_in;
    logic [2:0]        cons_bits;
    logic              byte_ready, cons_ready, flag, re_add, init_valid, err;
    logic [7:0]        bitstream;
    logic signed [3:0] bits_needed, bits_needed_sel;
    logic [15:0]       init_word;

    typedef struct {
        logic [3:0]  kind;
        logic [15:0] word;
        logic [7:0]  data;
        logic [3:0]  bits;
        logic [3:0]  sel;
    } exp_t;

    localparam logic [3:0] K_INIT = 4'b1000, K_RE = 4'b0100, K_FLAG = 4'b0010, K_ERR = 4'b0001;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   model_bn;

    bitstream_fetch_ctrl #(.INIT_BYTES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .cons_valid(cons_valid), .cons_ready(cons_ready),
        .cons_mode(cons_mode), .cons_bits(cons_bits),
        .bitstream(bitstream), .bits_needed(bits_needed),
        .bits_needed_sel(bits_needed_sel), .flag(flag), .re_add(re_add),
        .init_word(init_word), .init_valid(init_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] k;
        exp_t       e;
        k = {init_valid, re_add, flag, err};
        if (rst_n === 1'b1 && k != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(k), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", 32'(k), 32'(e.kind));
                if (e.kind == K_INIT) chk("init_word", 32'(init_word), 32'(e.word));
                if (e.kind == K_RE) begin
                    chk("re_bitstream", 32'(bitstream), 32'(e.data));
                    chk("re_bits_needed", 32'(bits_needed[3:0]), 32'(e.bits));
                end
                if (e.kind == K_FLAG) begin
                    chk("flag_bitstream", 32'(bitstream), 32'(e.data));
                    chk("flag_sel", 32'(bits_needed_sel[3:0]), 32'(e.sel));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({p, "_cons_ready"}, 32'(cons_ready), 32'd0);
        chk({p, "_bitstream"}, 32'(bitstream), 32'd0);
        chk({p, "_bits_needed"}, 32'(bits_needed[3:0]), 32'd0);
        chk({p, "_sel"}, 32'(bits_needed_sel[3:0]), 32'd0);
        chk({p, "_strobes"}, 32'({flag, re_add, init_valid, err}), 32'd0);
        chk({p, "_init_word"}, 32'(init_word), 32'd0);
    endtask

    task automatic init_bytes(input logic [7:0] b0, input logic [7:0] b1);
        exp_t e;
        e = '{kind: K_INIT, word: {b0, b1}, data: 8'h00, bits: 4'h0, sel: 4'h0};
        sb.push_back(e);
        byte_valid = 1'b1;
        byte_in    = b0;
        @(negedge clk);
        chk("init_byte_ready", 32'(byte_ready), 32'd1);
        chk("init_cons_ready", 32'(cons_ready), 32'd0);
        tick();
        byte_in = b1;
        @(negedge clk);
        chk("init_byte_ready2", 32'(byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
        model_bn   = -8;
    endtask

    task automatic do_init(input logic [7:0] b0, input logic [7:0] b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        init_bytes(b0, b1);
    endtask

    task automatic cons(input logic mode, input logic [2:0] bits, input logic present,
                        input logic [7:0] b, input int waits, input logic abort);
        int   s;
        logic bad;
        exp_t e;
        bad = mode && (bits == 3'd0 || bits > 3'd3);
        s   = model_bn + int'(bits);
        cons_valid = 1'b1;
        cons_mode  = mode;
        cons_bits  = bits;
        byte_valid = present;
        byte_in    = b;
        @(negedge clk);
        chk("cons_ready_run", 32'(cons_ready), 32'd1);
        chk("byte_ready_run", 32'(byte_ready), (!bad && s >= 0) ? 32'd1 : 32'd0);
        if (bad) begin
            e = '{kind: K_ERR, word: 16'h0, data: 8'h00, bits: 4'h0, sel: 4'h0};
            sb.push_back(e);
        end else if (s >= 0 && (present || !abort)) begin
            e = '{kind: mode ? K_FLAG : K_RE, word: 16'h0, data: b, bits: 4'(s), sel: model_bn[3:0]};
            sb.push_back(e);
        end
        tick();
        cons_valid = 1'b0;
        byte_valid = 1'b0;
        if (!bad && mode) chk("sel_at_accept", 32'(bits_needed_sel[3:0]), 32'(model_bn[3:0]));
        if (!bad) begin
            if (s < 0) begin
                model_bn = s;
            end else begin
                if (!present) begin
                    repeat (waits) begin
                        @(negedge clk);
                        chk("wait_cons_ready", 32'(cons_ready), 32'd0);
                        chk("wait_byte_ready", 32'(byte_ready), 32'd1);
                        tick();
                    end
                    byte_valid = 1'b1;
                    byte_in    = abort ? 8'hEE : b;
                    start      = abort;
                    tick();
                    start      = 1'b0;
                    byte_valid = 1'b0;
                end
                model_bn = s - 8;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog n_chk=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        logic       m;
        logic [2:0] bits;
        rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; cons_valid = 1'b0;
        cons_mode = 1'b0; cons_bits = 3'd0; byte_in = 8'h00; model_bn = -8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        byte_valid = 1'b1;
        @(negedge clk);
        chk("idle_byte_ready", 32'(byte_ready), 32'd0);
        tick();
        byte_valid = 1'b0;

        do_init(8'hA5, 8'h3C);
        cons(1'b0, 3'd5, 1'b0, 8'h00, 0, 1'b0);
        cons(1'b0, 3'd4, 1'b1, 8'h7E, 0, 1'b0);
        cons(1'b0, 3'd5, 1'b0, 8'h00, 0, 1'b0);
        cons(1'b1, 3'd3, 1'b0, 8'h11, 4, 1'b0);
        cons(1'b1, 3'd1, 1'b1, 8'h22, 0, 1'b0);
        cons(1'b1, 3'd4, 1'b1, 8'h33, 0, 1'b0);
        cons(1'b1, 3'd0, 1'b0, 8'h00, 0, 1'b0);
        cons(1'b0, 3'd0, 1'b1, 8'h44, 0, 1'b0);
        cons(1'b0, 3'd7, 1'b1, 8'h5A, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            m = 1'($urandom_range(0, 1));
            if (m) bits = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(1, 3));
            else   bits = 3'($urandom_range(0, 7));
            cons(m, bits, 1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        do_init(8'hC3, 8'h5A);
        cons(1'b0, 3'd7, 1'b0, 8'h00, 0, 1'b0);
        cons(1'b1, 3'd2, 1'b0, 8'h00, 2, 1'b1);
        init_bytes(8'h12, 8'h34);
        cons(1'b0, 3'd7, 1'b0, 8'h00, 0, 1'b0);
        cons(1'b0, 3'd3, 1'b1, 8'h99, 0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        tick();
        rst_n = 1'b1;

        do_init(8'h01, 8'h02);
        cons(1'b0, 3'd7, 1'b0, 8'h00, 0, 1'b0);
        cons_valid = 1'b1; cons_mode = 1'b1; cons_bits = 3'd2;
        tick();
        cons_valid = 1'b0;
        @(negedge clk);
        chk("held_cons_ready", 32'(cons_ready), 32'd0);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_in = 8'h77;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_byte_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/bitstream_fetch_ctrl.md
BITSTREAM_FETCH_CTRL -- requirements
Module: bitstream_fetch_ctrl

Interface
- REQ-001 Parameter INIT_BYTES, default 2: bytes packed MSB-first into init_word at slice start (legal 1..2).
- REQ-002 clk  in  1  single clock; all state on rising edge.
- REQ-003 rst_n  in  1  reset, asynchronous, active-low.
- REQ-004 start  in  1  one-cycle pulse: begin or restart slice init.
- REQ-005 byte_in  in  8  next bitstream byte.
- REQ-006 byte_valid  in  1 / byte_ready  out  1  byte handshake; transfer when both high.
- REQ-007 cons_valid  in  1 / cons_ready  out  1  consume-request handshake from bin decoder.
- REQ-008 cons_mode  in  1  0 = regular renorm, 1 = bypass group.
- REQ-009 cons_bits  in  3  regular: shift 0..7; bypass: bin count 1..3.
- REQ-010 bitstream  out  8  byte to byte-add datapath.
- REQ-011 bits_needed  out  4 signed  regular shift position for added byte.
- REQ-012 bits_needed_sel  out  4 signed  pre-group bitsNeeded for bypass bin select (-1/-2/-3).
- REQ-013 flag  out  1  bypass byte-add enable; re_add  out  1  regular byte-add strobe.
- REQ-014 init_word  out  16 / init_valid  out  1  initial m_value bytes, one-cycle strobe.
- REQ-015 err  out  1  one-cycle pulse on illegal request.

Function
- REQ-016 FSM states IDLE, INIT, RUN, WAIT_BYTE; internal bn register, 4-bit signed, range -8..-1 in RUN.
- REQ-017 IDLE: byte_ready=0, cons_ready=0; start -> INIT.
- REQ-018 INIT: byte_ready=1; shift accepted bytes into init_word; after INIT_BYTES-th byte: init_valid=1 next cycle, bn=-8, -> RUN.
- REQ-019 RUN: cons_ready=1; a request accepted on cons_valid&cons_ready.
- REQ-020 Regular: s=bn+cons_bits (5-bit signed); s<0 -> bn<=s, no byte; s>=0 -> byte required.
- REQ-021 Bypass k bins: s=bn+k; bits_needed_sel<=bn; s<0 -> bn<=s, flag=0; s>=0 -> byte required.
- REQ-022 Byte required with byte_valid high in the same cycle: byte_ready=1 combinationally, byte taken, outputs registered next cycle; otherwise -> WAIT_BYTE, cons_ready=0, request held.
- REQ-023 WAIT_BYTE: byte_ready=1; on transfer complete held request, -> RUN.
- REQ-024 On byte completion: bitstream<=byte; regular: bits_needed<=s, re_add=1; bypass: flag=1; bn<=s-8; strobes last exactly one cycle.
- REQ-025 Latency: request to datapath outputs = 1 cycle when byte present; otherwise 1 cycle after byte transfer.
- REQ-026 Regular cons_bits=0: accepted, no state change, no strobe.
- REQ-027 Bypass cons_bits 0 or >3: accepted, no state change, err=1.
- REQ-028 start in INIT/RUN/WAIT_BYTE: abort pending request, clear strobes, -> INIT; start wins over simultaneous cons/byte transfer.
- REQ-029 byte_ready never asserted in IDLE, or in RUN without required byte (non-prefetch build).

Reset
- REQ-030 rst_n low: state IDLE, bn=-8, bitstream=0, bits_needed=0, bits_needed_sel=0, flag=0, re_add=0, init_word=0, init_valid=0, err=0, byte_ready=0, cons_ready=0.
- REQ-031 Reset mid-WAIT_BYTE drops held request; no strobe after release.

Configuration
- REQ-032 BITSTREAM_FETCH_PREFETCH_EN defined: one-byte prefetch register filled in RUN whenever empty (byte_ready=1); byte-required requests use it with zero stall; cleared on start.
- REQ-033 Undefined: no prefetch register; behaviour exactly REQ-020..REQ-029.

Structure
- REQ-034 Shared package: FSM state enum, BN_RESET=-8, MAX_BYPASS_BINS=3, CONS_MODE_REGULAR/BYPASS constants.
- REQ-035 One sub-module: bitstream_prefetch_buf (single-entry valid/ready buffer), instantiated only under BITSTREAM_FETCH_PREFETCH_EN.

Verification
- REQ-036 start; bytes 0xA5,0x3C -> init_word=0xA53C, init_valid one cycle, bn=-8.
- REQ-037 bn=-8, regular 5 then 4, byte 0x7E valid -> 2nd: re_add=1, bits_needed=1, bitstream=0x7E, bn=-7.
- REQ-038 bn=-2, bypass 3, byte_valid low 4 cycles then 0x11 -> cons_ready=0 in wait, then flag=1, bits_needed_sel=-2, bn=-7.
- REQ-039 bypass cons_bits=4 -> err=1 one cycle, bn unchanged, no byte taken.
- REQ-040 start during WAIT_BYTE -> INIT, no flag/re_add; next two bytes form init_word.
- REQ-041 rst_n low mid-RUN -> all outputs per REQ-030 asynchronously.
